clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter DIV_A, default 2: integer divide ratio for clk_div2; legal range 2..256.
REQ-002 Parameter DIV_B, default 3: integer divide ratio for clk_div3; legal range 2..256.
REQ-003 Port clk  input  1  reference clock; the only clock in the block.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port clk_div2  output  1  clk divided by DIV_A, 50% duty.
REQ-006 Port clk_div3  output  1  clk divided by DIV_B, 50% duty.
REQ-007 Both outputs SHALL be produced by one shared divider structure, instantiated twice and sized from its ratio: counter width = clog2(N).

Function
REQ-008 Each output SHALL have period N clk periods, where N is the channel ratio (DIV_A or DIV_B).
REQ-009 Even N: the output SHALL toggle on every (N/2)-th rising clk edge after reset release, with the first toggle going 0->1; high time = low time = N/2 periods.
REQ-010 Odd N: the output SHALL rise on rising clk edges 1, N+1, 2N+1, … after reset release, and fall on the falling clk edge immediately after rising edge (N+1)/2 of each cycle; high time = low time = N/2 periods (x.5).
REQ-011 Odd-N implementation: a mod-N counter on the rising edge, a rising-edge flop and a falling-edge flop; the output is the combination of those flops only, with no combinational decode of the counter driving the output directly.
REQ-012 The mod-N counter SHALL count 0..N-1 and wrap to 0; it SHALL never hold a value >= N.
REQ-013 Outputs SHALL be glitch-free: at most one transition per clk half-period, with no runt pulses at wrap-around.
REQ-014 The phase relationship is fixed: both outputs rise together on the first rising clk edge after reset release.
REQ-015 Ratios outside 2..256 SHALL be rejected at elaboration with a fatal error.
REQ-016 DIV_A and DIV_B SHALL be independent; equal values are legal and then produce identical waveforms.

Reset
REQ-017 rst_n low SHALL immediately force clk_div2 = 0, clk_div3 = 0, all counters = 0 and all rising-edge and falling-edge flops = 0, with no clock required.
REQ-018 rst_n deassertion SHALL take effect at the next rising clk edge; deassertion coincident with a rising edge SHALL be treated as occurring after that edge.
REQ-019 Reset asserted mid-cycle (either output high) SHALL drive both outputs low within reset propagation delay; after release, sequencing SHALL restart exactly as in REQ-009/REQ-010.
REQ-020 While rst_n is low, outputs SHALL stay 0 regardless of clk activity.

Verification
(clk period 10 ns, rising edges at 5, 15, 25 … ns; rst_n low 0–12 ns unless noted; default parameters.)
REQ-021 Basic div2: after release -> clk_div2 = 1 at 15 ns, 0 at 25, 1 at 35; period 20 ns, high 10 ns; hold for 1000 ns with no missing edges.
REQ-022 Basic div3: after release -> clk_div3 = 1 at 15 ns, 0 at 30, 1 at 45, 0 at 60; period 30 ns, high 15 ns, sustained over 1000 ns.
REQ-023 Reset mid-run: pull rst_n low at 47 ns (clk_div3 high) -> both outputs 0 by 47 ns + delay; release at 62 ns -> both outputs rise at 65 ns and the REQ-021/REQ-022 patterns repeat, shifted.
REQ-024 Clock stopped in reset: hold rst_n low while toggling clk for 100 ns -> both outputs constant 0.
REQ-025 Parameter sweep: DIV_A = 4, DIV_B = 5 -> clk_div2 period 40 ns with high 20 ns (rising at 25 ns); clk_div3 period 50 ns with high 25 ns (rising at 15 ns, falling at 40 ns); duty checked over 20 output periods.
REQ-026 Illegal ratio: DIV_B = 1 -> elaboration fails with a fatal message.

Source files
------------

// File: rtl/clock_divider.sv
// Two independent 50%-duty integer clock dividers built from one shared channel.
// Even ratios toggle a single flop; odd ratios OR a rising-edge and a falling-edge flop.

module clock_divider_chan #(
   parameter int N = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_clk
);

   localparam int W = (N < 2) ? 1 : $clog2(N);
   localparam logic [W-1:0] C_LAST = W'(N - 1);

   logic [W-1:0] r_cnt;

   if ((N < 2) || (N > 256)) begin : g_bad_ratio
      $fatal(1, "clock_divider_chan: ratio %0d outside legal range 2..256", N);
   end

   // Mod-N counter: 0..N-1, wraps explicitly so it never holds a value >= N.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= {W{1'b0}};
      end else if (r_cnt == C_LAST) begin
         r_cnt <= {W{1'b0}};
      end else begin
         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end

   if ((N % 2) == 0) begin : g_even
      localparam logic [W-1:0] C_HALF = W'((N / 2) - 1);

      logic r_out;
      logic w_toggle;

      // Toggle at the end of each half-cycle, i.e. rising edges N/2, N, 3N/2, ...
      assign w_toggle = (r_cnt == C_HALF) || (r_cnt == C_LAST);

      // Output flop toggles once per half output period.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_out <= 1'b0;
         end else if (w_toggle) begin
            r_out <= ~r_out;
         end else begin
            r_out <= r_out;
         end
      end

      assign o_clk = r_out;
   end else begin : g_odd
      localparam logic [W-1:0] C_ODDH = W'((N - 1) / 2);

      logic r_pos;
      logic r_neg;

      // Rising-edge flop is high for (N-1)/2 clk periods starting at count 0.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_pos <= 1'b0;
         end else begin
            r_pos <= (r_cnt < C_ODDH);
         end
      end

      // Half-period delayed copy stretches the high phase by the extra half clk.
      always_ff @(negedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_neg <= 1'b0;
         end else begin
            r_neg <= r_pos;
         end
      end

      assign o_clk = r_pos | r_neg;
   end

endmodule

module clock_divider #(
   parameter int DIV_A = 2,
   parameter int DIV_B = 3
) (
   input  logic clk,
   input  logic rst_n,
   output logic clk_div2,
   output logic clk_div3
);

   clock_divider_chan #(.N(DIV_A)) u_chan_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_clk   (clk_div2)
   );

   clock_divider_chan #(.N(DIV_B)) u_chan_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_clk   (clk_div3)
   );

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: default ratios (2,3) and a 4/5 instance share clk and rst_n.
`timescale 1ns/1ps

module tb_clock_divider;

   logic clk;
   logic rst_n;
   logic w_div2;
   logic w_div3;
   logic w_d45_2;
   logic w_d45_3;

   int n_tests = 0;
   int n_fail  = 0;

   clock_divider dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_div2 (w_div2),
      .clk_div3 (w_div3)
   );

   clock_divider #(.DIV_A(4), .DIV_B(5)) dut45 (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_div2 (w_d45_2),
      .clk_div3 (w_d45_3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic wait_until(input int t);
      #(t - $time);
   endtask

   // Expected divider output at time t (ns) given the first rising edge after release te.
   function automatic logic exp_out(input int n, input int t, input int te);
      int d;
      int k;
      if (t < te) return 1'b0;
      d = t - te;
      if ((n % 2) == 0) begin
         k = d / 10 + 1;
         return ((k / (n / 2)) % 2) == 1;
      end
      return (d % (10 * n)) < (((n - 1) / 2) * 10 + 5);
   endfunction

   task automatic test_reset();
      int t_tab[3] = '{3, 7, 11};
      rst_n = 1'b0;
      foreach (t_tab[i]) begin
         wait_until(t_tab[i]);
         if ({w_div2, w_div3, w_d45_2, w_d45_3} !== 4'b0000) begin
            $display("FAIL reset t=%0t got=%b exp=0000", $time, {w_div2, w_div3, w_d45_2, w_d45_3});
            n_fail++;
         end
         n_tests++;
      end
   endtask

   task automatic test_startup();
      int         t_tab[7] = '{16, 21, 26, 31, 36, 41, 46};
      logic [3:0] e_tab[7] = '{4'b1101, 4'b1101, 4'b0111, 4'b0011, 4'b1011, 4'b1010, 4'b0100};
      wait_until(12);
      rst_n = 1'b1;
      foreach (t_tab[i]) begin
         wait_until(t_tab[i]);
         if ({w_div2, w_div3, w_d45_2, w_d45_3} !== e_tab[i]) begin
            $display("FAIL startup t=%0t got=%b exp=%b", $time, {w_div2, w_div3, w_d45_2, w_d45_3}, e_tab[i]);
            n_fail++;
         end
         n_tests++;
      end
   endtask

   task automatic test_mid_reset();
      int t_tab[4] = '{48, 55, 61, 63};
      wait_until(47);
      rst_n = 1'b0;
      foreach (t_tab[i]) begin
         if (t_tab[i] == 63) begin
            wait_until(62);
            rst_n = 1'b1;
         end
         wait_until(t_tab[i]);
         if ({w_div2, w_div3, w_d45_2, w_d45_3} !== 4'b0000) begin
            $display("FAIL mid_reset t=%0t got=%b exp=0000", $time, {w_div2, w_div3, w_d45_2, w_d45_3});
            n_fail++;
         end
         n_tests++;
      end
      wait_until(66);
      if ({w_div2, w_div3, w_d45_2, w_d45_3} !== 4'b1101) begin
         $display("FAIL restart_edge t=%0t got=%b exp=1101", $time, {w_div2, w_div3, w_d45_2, w_d45_3});
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_sustained(input int te, input int t_end);
      logic [3:0] e;
      for (int t = te + 2; t <= t_end; t += 5) begin
         wait_until(t);
         e = {exp_out(2, t, te), exp_out(3, t, te), exp_out(4, t, te), exp_out(5, t, te)};
         if ({w_div2, w_div3, w_d45_2, w_d45_3} !== e) begin
            $display("FAIL sustained t=%0t got=%b exp=%b", $time, {w_div2, w_div3, w_d45_2, w_d45_3}, e);
            n_fail++;
         end
         n_tests++;
      end
   endtask

   task automatic test_clock_in_reset();
      wait_until(1068);
      rst_n = 1'b0;
      for (int t = 1069; t <= 1169; t += 5) begin
         wait_until(t);
         if ({w_div2, w_div3, w_d45_2, w_d45_3} !== 4'b0000) begin
            $display("FAIL clk_in_reset t=%0t got=%b exp=0000", $time, {w_div2, w_div3, w_d45_2, w_d45_3});
            n_fail++;
         end
         n_tests++;
      end
      wait_until(1172);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_startup();
      test_mid_reset();
      test_sustained(65, 1066);
      test_clock_in_reset();
      test_sustained(1175, 1400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
